mdu_divider: RTL and testbench
==============================

Name: mdu_divider

Overview:
- Iterative 32-bit integer divider for the mini MIPS execute stage; implements DIV/DIVU and produces the values written to HI (remainder) and LO (quotient).
- Pairs with the combinational ALU slice:
  - ALU/control side issues a one-cycle start.
  - Divider returns a one-cycle done pulse with registered results that hold until the next accepted start.
- Restoring shift-subtract algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 2.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- is_signed  input  1  1 = DIV (two's complement), 0 = DIVU
- dividend  input  WIDTH  numerator; sampled with start
- divisor  input  WIDTH  denominator; sampled with start
- busy  output  1  operation in progress
- done  output  1  one-cycle pulse; results valid from this cycle
- quotient  output  WIDTH  LO value
- remainder  output  WIDTH  HI value
- div_by_zero  output  1  last accepted operation had divisor == 0

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; busy, done, div_by_zero = 0; quotient, remainder, counter and internal registers = 0.
- Reset mid-operation: operation is abandoned; no done pulse follows rst_n deassertion.
- States: IDLE, RUN, FIX.
- IDLE:
  - done is cleared on every edge that does not itself complete an operation.
  - start = 0: no change.
  - start = 1, divisor != 0: latch operand magnitudes (negate a negative operand only when is_signed = 1) and both sign bits; clear partial remainder; counter = 0; busy = 1; state -> RUN.
  - start = 1, divisor == 0: on the same edge, quotient = all ones, remainder = dividend (unmodified), div_by_zero = 1, done = 1, busy stays 0; state stays IDLE.
- RUN, each edge:
  - Shift {partial remainder, magnitude quotient} left by 1.
  - Trial-subtract the divisor magnitude using a WIDTH+1-bit subtractor.
  - If no borrow: keep the difference and set quotient LSB = 1; otherwise restore and set LSB = 0.
  - Counter increments; after the WIDTH-th iteration, state -> FIX.
- FIX, one edge:
  - quotient = magnitude quotient, negated if is_signed and sign(dividend) != sign(divisor).
  - remainder = magnitude remainder, negated if is_signed and dividend is negative.
  - div_by_zero = 0; done = 1; busy = 0; state -> IDLE.
- Latency: start sampled at edge k -> done high after edge k+WIDTH+1 (33 cycles at default); divide-by-zero case -> done after edge k.
- start while busy: ignored; operand inputs are don't-care after the sampling edge.
- start high during the done cycle (state IDLE): accepted; back-to-back issue is allowed.
- Signed overflow (dividend = most-negative value, divisor = -1): quotient = 0x80000000, remainder = 0, no flag.
- Remainder is 0 or takes the sign of the dividend; |remainder| < |divisor|.
- quotient, remainder and div_by_zero hold their values between done pulses.

Test Plan:
- Unsigned: is_signed = 0, 100 / 7, start at edge 0 -> busy rises, done pulses exactly once after edge 33, quotient = 14, remainder = 2, div_by_zero = 0.
- Signed mixed signs: -7 / 2 -> quotient = 0xFFFFFFFD, remainder = 0xFFFFFFFF; 7 / -2 -> quotient = 0xFFFFFFFD, remainder = 1; unsigned 0xFFFFFFF9 / 2 -> quotient = 0x7FFFFFFC, remainder = 1.
- Divide by zero: 0x12345678 / 0 -> done after 1 edge, quotient = 0xFFFFFFFF, remainder = 0x12345678, div_by_zero = 1, busy never rises; a following 9 / 3 clears div_by_zero.
- Overflow and extremes: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned 0xFFFFFFFF / 1 -> quotient 0xFFFFFFFF, remainder 0; 5 / 9 -> quotient 0, remainder 5.
- Handshake:
  - start pulsed again at cycle 10 with different operands -> ignored, first result unchanged.
  - start held high on the done cycle -> second operation accepted, second done 33 cycles later.
- Reset mid-run: rst_n low at cycle 12 -> busy, done, quotient and remainder read 0 immediately (asynchronous); no done after release; a new 50 / 5 then yields quotient 10, remainder 0.

Source files
------------

// File: rtl/mdu_divider.sv
// mdu_divider: iterative restoring divider for DIV/DIVU, HI = remainder, LO = quotient
module mdu_divider #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] mq_q, mq_d, dvs_q, dvs_d, pr_q, pr_d, quo_q, quo_d, rem_q, rem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             nd_q, nd_d, ns_q, ns_d, busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic [WIDTH:0]   shifted, diff;
    logic             borrow;

    // partial remainder is always below the divisor, so the top bit of the
    // WIDTH+1-bit difference is set exactly when the trial subtract borrows
    assign shifted = {pr_q, mq_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};
    assign borrow  = diff[WIDTH];

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

    // next-state: operand capture, one quotient bit per RUN cycle, sign fix-up
    always_comb begin
        state_d = state_q;
        mq_d    = mq_q;
        dvs_d   = dvs_q;
        pr_d    = pr_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        nd_d    = nd_q;
        ns_d    = ns_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            IDLE: begin
                if (start && divisor == '0) begin
                    quo_d  = '1;
                    rem_d  = dividend;
                    dbz_d  = 1'b1;
                    done_d = 1'b1;
                end else if (start) begin
                    nd_d    = is_signed & dividend[WIDTH-1];
                    ns_d    = is_signed & divisor[WIDTH-1];
                    mq_d    = nd_d ? -dividend : dividend;
                    dvs_d   = ns_d ? -divisor : divisor;
                    pr_d    = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                pr_d    = borrow ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                mq_d    = {mq_q[WIDTH-2:0], ~borrow};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CNT_W'(WIDTH - 1)) ? FIX : RUN;
            end
            FIX: begin
                quo_d   = (nd_q ^ ns_q) ? -mq_q : mq_q;
                rem_d   = nd_q ? -pr_q : pr_q;
                dbz_d   = 1'b0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state registers, cleared asynchronously so a reset abandons any operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mq_q    <= '0;
            dvs_q   <= '0;
            pr_q    <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            nd_q    <= 1'b0;
            ns_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mq_q    <= mq_d;
            dvs_q   <= dvs_d;
            pr_q    <= pr_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            nd_q    <= nd_d;
            ns_q    <= ns_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end
endmodule

// File: tb/tb_mdu_divider.sv
// tb_mdu_divider: scoreboard bench for mdu_divider with directed vectors
module tb_mdu_divider;
    logic        clk, rst_n, start, is_signed;
    logic [31:0] dividend, divisor, quotient, remainder;
    logic        busy, done, div_by_zero;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          c;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;
    int   cyc;
    int   n_cmp;
    int   n_bad;

    mdu_divider dut (
        .clk(clk), .rst_n(rst_n), .start(start), .is_signed(is_signed),
        .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [31:0] eq, input logic [31:0] er, input logic ez);
        exp_t e;
        dividend  = a;
        divisor   = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.q = eq;
        e.r = er;
        e.z = ez;
        e.c = cyc + (ez ? 0 : 33);
        sb.push_back(e);
        @(negedge clk);
        chk("busy_after_start", {31'b0, busy}, {31'b0, !ez});
    endtask

    task automatic wait_idle();
        int i;
        for (i = 0; i < 100 && (sb.size() != 0 || busy); i++) @(negedge clk);
        if (i == 100) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: still %0d pending, busy %b", sb.size(), busy);
            sb.delete();
        end
        @(negedge clk);
    endtask

    // monitor: every done pulse must match the oldest expectation, on time
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
            end else begin
                e_mon = sb.pop_front();
                chk("quotient", quotient, e_mon.q);
                chk("remainder", remainder, e_mon.r);
                chk("div_by_zero", {31'b0, div_by_zero}, {31'b0, e_mon.z});
                chk("done_cycle", cyc, e_mon.c);
            end
        end
    end

    initial begin
        int i;
        rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        #1;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", {31'b0, div_by_zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // basic unsigned, plus a start pulse mid-run that must be ignored
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (8) @(negedge clk);
        dividend = 32'd1; divisor = 32'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("hold_q", quotient, 32'd14);
        chk("hold_r", remainder, 32'd2);

        issue(32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        wait_idle();
        issue(32'd7, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1, 1'b0);
        wait_idle();
        issue(32'hFFFFFFF9, 32'd2, 1'b0, 32'h7FFFFFFC, 32'd1, 1'b0);
        wait_idle();

        issue(32'h12345678, 32'd0, 1'b0, 32'hFFFFFFFF, 32'h12345678, 1'b1);
        wait_idle();
        chk("dbz_hold", {31'b0, div_by_zero}, 1);
        issue(32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 1'b0);
        wait_idle();

        issue(32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0, 1'b0);
        wait_idle();
        issue(32'hFFFFFFFF, 32'd1, 1'b0, 32'hFFFFFFFF, 32'd0, 1'b0);
        wait_idle();
        issue(32'd5, 32'd9, 1'b0, 32'd0, 32'd5, 1'b0);
        wait_idle();

        // back-to-back: second start issued during the done cycle
        issue(32'd1000, 32'd10, 1'b0, 32'd100, 32'd0, 1'b0);
        for (i = 0; i < 60 && !done; i++) @(negedge clk);
        chk("b2b_done_seen", {31'b0, done}, 1);
        issue(32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFF2, 32'hFFFFFFFE, 1'b0);
        wait_idle();

        // asynchronous reset in the middle of a run
        issue(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        repeat (10) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", {31'b0, busy}, 0);
        chk("midrst_done", {31'b0, done}, 0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("post_rst_busy", {31'b0, busy}, 0);
        issue(32'd50, 32'd5, 1'b0, 32'd10, 32'd0, 1'b0);
        wait_idle();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
